// File: rtl/axis_pkg.sv
// Shared AXI-Stream FIFO types and default sizing.
// The optional store-and-forward mode is AXIS_SYNC_FIFO_PKT_MODE_EN.
package axis_pkg;

  localparam int AXIS_DATA_W = 32;
  localparam int AXIS_DEPTH  = 16;

  typedef logic [AXIS_DATA_W-1:0] tdata_t;

  typedef struct packed {
    logic   tlast;
    tdata_t tdata;
  } axis_beat_t;

endpackage

// File: rtl/axis_fifo_mem.sv
// Simple dual-port beat storage.
// Registered write, asynchronous read, contents not reset.
module axis_fifo_mem #(
  parameter int W     = 33,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_sync_fifo.sv
// Synchronous AXI-Stream FIFO with fill level and packet count.
// Define AXIS_SYNC_FIFO_PKT_MODE_EN for store-and-forward output.
module axis_sync_fifo
  import axis_pkg::*;
#(
  parameter int DATA_W  = AXIS_DATA_W,
  parameter int DEPTH   = AXIS_DEPTH,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  output logic              s_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready,
  output logic [CNT_W-1:0]  fill_level,
  output logic [CNT_W-1:0]  pkt_count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [DATA_W:0] rd_beat;
  logic            wr;
  logic            rd;
  logic            full;
  logic            empty;
  logic            pkt_inc;
  logic            pkt_dec;

  assign full  = (fill_level == CNT_W'(DEPTH));
  assign empty = (fill_level == '0);

  // Ready comes only from stored state, never from m_tready.
  assign s_tready = !rst && !full;
  assign wr       = s_tvalid && s_tready;
  assign rd       = m_tvalid && m_tready;

  assign m_tdata = rd_beat[DATA_W-1:0];
  assign m_tlast = rd_beat[DATA_W];

  assign pkt_inc = wr && s_tlast;
  assign pkt_dec = rd && m_tlast;

`ifdef AXIS_SYNC_FIFO_PKT_MODE_EN
  logic release_q;

  // A full FIFO with no complete packet must stream out to avoid deadlock.
  always_ff @(posedge clk) begin
    if (rst) begin
      release_q <= 1'b0;
    end else if (pkt_dec) begin
      release_q <= 1'b0;
    end else if (full && pkt_count == '0) begin
      release_q <= 1'b1;
    end
  end

  assign m_tvalid = !empty &&
    ((pkt_count != '0) || full || release_q);
`else
  assign m_tvalid = !empty;
`endif

  axis_fifo_mem #(
    .W     (DATA_W + 1),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr),
    .waddr (wr_ptr),
    .wdata ({s_tlast, s_tdata}),
    .raddr (rd_ptr),
    .rdata (rd_beat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      pkt_count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr, rd})
        2'b10:   fill_level <= fill_level + CNT_W'(1);
        2'b01:   fill_level <= fill_level - CNT_W'(1);
        default: fill_level <= fill_level;
      endcase
      unique case ({pkt_inc, pkt_dec})
        2'b10:   pkt_count <= pkt_count + CNT_W'(1);
        2'b01:   pkt_count <= pkt_count - CNT_W'(1);
        default: pkt_count <= pkt_count;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_sync_fifo.sv
// Directed self-checking bench for axis_sync_fifo.
// Store-and-forward checks build with AXIS_SYNC_FIFO_PKT_MODE_EN.
module tb_axis_sync_fifo;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] s_tdata;
  logic              s_tvalid;
  logic              s_tlast;
  logic              s_tready;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tlast;
  logic              m_tready;
  logic [CNT_W-1:0]  fill_level;
  logic [CNT_W-1:0]  pkt_count;

  int tests;
  int fails;

  axis_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tlast    (s_tlast),
    .s_tready   (s_tready),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tlast    (m_tlast),
    .m_tready   (m_tready),
    .fill_level (fill_level),
    .pkt_count  (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      tests++;
      if (fill_level > CNT_W'(DEPTH) || pkt_count > fill_level) begin
        fails++;
        $display("FAIL invariant: fill=%0d pkt=%0d", fill_level, pkt_count);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    s_tdata = '0;
    m_tready = 1'b0;
    repeat (3) step();
    tests++;
    if (s_tready !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready_low: got %b want 0", s_tready);
    end
    rst = 1'b0;
    step();
    tests++;
    if (fill_level !== 0 || pkt_count !== 0 || m_tvalid !== 1'b0 ||
        s_tready !== 1'b1) begin
      fails++;
      $display("FAIL reset_state: fill=%0d pkt=%0d mv=%b sr=%b want 0 0 0 1",
               fill_level, pkt_count, m_tvalid, s_tready);
    end
  endtask

  task automatic test_fill();
    m_tready = 1'b0;
    s_tlast = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      s_tdata = DATA_W'(i);
      s_tvalid = 1'b1;
      step();
      tests++;
      if (fill_level !== CNT_W'(i + 1)) begin
        fails++;
        $display("FAIL fill_count: got %0d want %0d", fill_level, i + 1);
      end
    end
    tests++;
    if (s_tready !== 1'b0) begin
      fails++;
      $display("FAIL full_ready: got %b want 0", s_tready);
    end
    s_tdata = 32'h10;
    step();
    tests++;
    if (fill_level !== 16 || s_tready !== 1'b0 || m_tvalid !== 1'b1 ||
        m_tdata !== 32'h0) begin
      fails++;
      $display("FAIL full_hold: fill=%0d sr=%b mv=%b d=%h want 16 0 1 0",
               fill_level, s_tready, m_tvalid, m_tdata);
    end
  endtask

  task automatic test_full_read();
    int exp;
    m_tready = 1'b1;
    tests++;
    if (m_tdata !== 32'h0) begin
      fails++;
      $display("FAIL full_read_data: got %h want 0", m_tdata);
    end
    step();
    m_tready = 1'b0;
    tests++;
    if (fill_level !== 15 || s_tready !== 1'b1 || m_tdata !== 32'h1) begin
      fails++;
      $display("FAIL full_read_after: fill=%0d sr=%b d=%h want 15 1 1",
               fill_level, s_tready, m_tdata);
    end
    step();
    s_tvalid = 1'b0;
    tests++;
    if (fill_level !== 16) begin
      fails++;
      $display("FAIL full_refill: got %0d want 16", fill_level);
    end
    m_tready = 1'b1;
    exp = 1;
    for (int c = 0; c < 40 && exp <= 16; c++) begin
      if (m_tvalid) begin
        tests++;
        if (m_tdata !== DATA_W'(exp)) begin
          fails++;
          $display("FAIL drain_data: got %h want %h", m_tdata, exp);
        end
        exp++;
      end
      step();
    end
    m_tready = 1'b0;
    tests++;
    if (exp != 17 || fill_level !== 0) begin
      fails++;
      $display("FAIL drain_done: beats=%0d fill=%0d want 16 0",
               exp - 1, fill_level);
    end
  endtask

  task automatic test_stream();
    logic [DATA_W-1:0] d [100];
    s_tlast = 1'b0;
    for (int c = 0; c <= 100; c++) begin
      if (c < 100) begin
        d[c] = $urandom;
        s_tdata = d[c];
        s_tvalid = 1'b1;
      end else begin
        s_tvalid = 1'b0;
      end
      m_tready = 1'b1;
      tests++;
      if (c == 0) begin
        if (m_tvalid !== 1'b0) begin
          fails++;
          $display("FAIL stream_no_bypass: mv=%b want 0", m_tvalid);
        end
      end else if (m_tvalid !== 1'b1 || m_tdata !== d[c-1] ||
                   fill_level !== 1) begin
        fails++;
        $display("FAIL stream_beat %0d: mv=%b d=%h fill=%0d want 1 %h 1",
                 c - 1, m_tvalid, m_tdata, fill_level, d[c-1]);
      end
      step();
    end
    m_tready = 1'b0;
    tests++;
    if (fill_level !== 0 || m_tvalid !== 1'b0) begin
      fails++;
      $display("FAIL stream_end: fill=%0d mv=%b want 0 0",
               fill_level, m_tvalid);
    end
  endtask

  task automatic test_packets();
    int i;
    m_tready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      s_tdata = 32'hA0 + DATA_W'(k);
      s_tlast = (k == 0 || k == 3 || k == 8);
      s_tvalid = 1'b1;
      step();
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    tests++;
    if (pkt_count !== 3 || fill_level !== 9) begin
      fails++;
      $display("FAIL pkt_peak: pkt=%0d fill=%0d want 3 9",
               pkt_count, fill_level);
    end
    i = 0;
    for (int c = 0; c < 200 && i < 9; c++) begin
      m_tready = 1'($urandom_range(0, 1));
      if (m_tvalid && m_tready) begin
        tests++;
        if (m_tdata !== 32'hA0 + DATA_W'(i) ||
            m_tlast !== (i == 0 || i == 3 || i == 8)) begin
          fails++;
          $display("FAIL pkt_beat %0d: d=%h last=%b", i, m_tdata, m_tlast);
        end
        i++;
      end
      step();
    end
    m_tready = 1'b0;
    tests++;
    if (i != 9 || pkt_count !== 0 || fill_level !== 0) begin
      fails++;
      $display("FAIL pkt_drain: beats=%0d pkt=%0d fill=%0d want 9 0 0",
               i, pkt_count, fill_level);
    end
  endtask

  task automatic test_reset_mid();
    int i;
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    s_tdata = 32'hD0;
    s_tlast = 1'b1;
    step();
    s_tlast = 1'b0;
    s_tdata = 32'hB0;
    step();
    s_tdata = 32'hB1;
    step();
    s_tvalid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++;
    if (fill_level !== 0 || pkt_count !== 0 || m_tvalid !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: fill=%0d pkt=%0d mv=%b want 0 0 0",
               fill_level, pkt_count, m_tvalid);
    end
    for (int k = 0; k < 3; k++) begin
      s_tvalid = 1'b1;
      s_tdata = 32'hC0 + DATA_W'(k);
      s_tlast = (k == 2);
      step();
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    m_tready = 1'b1;
    i = 0;
    for (int c = 0; c < 20 && i < 3; c++) begin
      if (m_tvalid) begin
        tests++;
        if (m_tdata !== 32'hC0 + DATA_W'(i) || m_tlast !== (i == 2)) begin
          fails++;
          $display("FAIL fresh_beat %0d: d=%h last=%b", i, m_tdata, m_tlast);
        end
        i++;
      end
      step();
    end
    m_tready = 1'b0;
    tests++;
    if (i != 3 || fill_level !== 0) begin
      fails++;
      $display("FAIL fresh_done: beats=%0d fill=%0d want 3 0", i, fill_level);
    end
  endtask

`ifdef AXIS_SYNC_FIFO_PKT_MODE_EN
  task automatic test_pkt_hold();
    int i;
    m_tready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s_tvalid = 1'b1;
      s_tdata = 32'h200 + DATA_W'(k);
      s_tlast = (k == 2);
      step();
      tests++;
      if (m_tvalid !== (k == 2)) begin
        fails++;
        $display("FAIL hold_valid %0d: mv=%b", k, m_tvalid);
      end
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    m_tready = 1'b1;
    i = 0;
    for (int c = 0; c < 20 && i < 3; c++) begin
      if (m_tvalid) begin
        tests++;
        if (m_tdata !== 32'h200 + DATA_W'(i) || m_tlast !== (i == 2)) begin
          fails++;
          $display("FAIL hold_beat %0d: d=%h last=%b", i, m_tdata, m_tlast);
        end
        i++;
      end
      step();
    end
    m_tready = 1'b0;
    tests++;
    if (i != 3 || fill_level !== 0) begin
      fails++;
      $display("FAIL hold_done: beats=%0d fill=%0d", i, fill_level);
    end
  endtask

  task automatic test_pkt_oversize();
    int snd;
    int rcv;
    m_tready = 1'b0;
    s_tlast = 1'b0;
    for (int k = 0; k < 16; k++) begin
      s_tvalid = 1'b1;
      s_tdata = 32'h100 + DATA_W'(k);
      step();
      tests++;
      if (m_tvalid !== (k == 15)) begin
        fails++;
        $display("FAIL big_valid %0d: mv=%b", k, m_tvalid);
      end
    end
    snd = 16;
    rcv = 0;
    for (int c = 0; c < 100 && rcv < 20; c++) begin
      if (snd < 20) begin
        s_tvalid = 1'b1;
        s_tdata = 32'h100 + DATA_W'(snd);
        s_tlast = (snd == 19);
      end else begin
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
      end
      m_tready = 1'b1;
      if (m_tvalid) begin
        tests++;
        if (m_tdata !== 32'h100 + DATA_W'(rcv) || m_tlast !== (rcv == 19)) begin
          fails++;
          $display("FAIL big_beat %0d: d=%h last=%b", rcv, m_tdata, m_tlast);
        end
        rcv++;
      end
      if (s_tvalid && s_tready) snd++;
      step();
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    m_tready = 1'b0;
    tests++;
    if (rcv != 20 || fill_level !== 0 || m_tvalid !== 1'b0 ||
        u_dut.release_q !== 1'b0) begin
      fails++;
      $display("FAIL big_done: beats=%0d fill=%0d mv=%b rel=%b want 20 0 0 0",
               rcv, fill_level, m_tvalid, u_dut.release_q);
    end
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    s_tdata = '0;
    m_tready = 1'b0;
    test_reset();
    test_fill();
    test_full_read();
    test_stream();
    test_packets();
    test_reset_mid();
`ifdef AXIS_SYNC_FIFO_PKT_MODE_EN
    test_pkt_hold();
    test_pkt_oversize();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axis_sync_fifo.md
Name: axis_sync_fifo

Overview:
- Synchronous AXI-Stream FIFO.
- Sits directly upstream of the stream consumer: accepts beats on a slave port (tdata/tvalid/tready/tlast) and presents them, in order, on a master port.
- Decouples producer backpressure from consumer timing and breaks the combinational tready path.
- Reports fill level and complete-packet count for flow-control and debug.

Parameters:
- DATA_W, 32, tdata width in bits.
- DEPTH, 16, number of beat entries; power of two, >= 4.
- CNT_W, $clog2(DEPTH+1), width of the fill-level output (derived, not overridden).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- s_tdata  in  DATA_W  slave data.
- s_tvalid  in  1  slave beat valid.
- s_tlast  in  1  slave end-of-packet.
- s_tready  out  1  slave ready.
- m_tdata  out  DATA_W  master data.
- m_tvalid  out  1  master beat valid.
- m_tlast  out  1  master end-of-packet.
- m_tready  in  1  master ready.
- fill_level  out  CNT_W  entries currently stored (0..DEPTH).
- pkt_count  out  CNT_W  stored beats with tlast=1.

Behaviour:
- Storage and pointers:
  - Storage array of DEPTH entries of {tlast, tdata}.
  - Read and write pointers of $clog2(DEPTH) bits, wrapping naturally from DEPTH-1 to 0.
  - Separate occupancy counter of CNT_W bits.
- Handshakes:
  - Write occurs when s_tvalid && s_tready.
  - Read occurs when m_tvalid && m_tready.
- s_tready:
  - s_tready = (fill_level != DEPTH); registered-state-derived, with no combinational dependence on m_tready.
  - When full, no write is accepted even if a read happens the same cycle; s_tready rises the cycle after the read.
- m_tvalid and m_tdata/m_tlast:
  - m_tvalid = (fill_level != 0), subject to the optional-feature gating below.
  - m_tdata and m_tlast are driven from the entry at the read pointer (first-word fall-through from storage).
- Latency:
  - A beat accepted in cycle N is visible on m_* in cycle N+1.
  - This holds even when the FIFO was empty in cycle N; there is no bypass path.
- Simultaneous read and write with 0 < fill_level < DEPTH:
  - Both pointers advance; fill_level is unchanged.
- Empty:
  - m_tvalid = 0.
  - m_tdata and m_tlast hold the stale entry value; consumers must not sample them.
- pkt_count:
  - Increments on write of a beat with s_tlast=1.
  - Decrements on read of a beat with m_tlast=1.
  - A simultaneous increment and decrement leaves it unchanged.
- Master stability:
  - Once m_tvalid is asserted, m_tdata, m_tlast and m_tvalid hold until m_tready (AXI-Stream rule, guaranteed by construction).
- Reset:
  - Pointers, fill_level and pkt_count clear to 0.
  - s_tready=1 from the first cycle after reset (reset term: s_tready=0 while rst=1).
  - m_tvalid=0.
  - Storage contents are not reset.
- Reset mid-packet:
  - All stored beats, including a partial packet, are discarded.
  - No tlast is synthesised.
- No overflow or underflow is possible by construction.
- The bench asserts fill_level <= DEPTH and pkt_count <= fill_level.

Optional Feature:
- Macro: AXIS_SYNC_FIFO_PKT_MODE_EN.
- Defined (store-and-forward):
  - m_tvalid = (fill_level != 0) && ((pkt_count != 0) || (fill_level == DEPTH) || release_q).
  - release_q sets when a full-with-no-complete-packet release starts.
  - release_q clears when a beat with m_tlast=1 is read.
  - release_q resets to 0.
  - Oversized packets therefore stream through without deadlock.
- Undefined: cut-through as in Behaviour; release_q is not built.

Decomposition:
- Shared package axis_pkg:
  - tdata_t typedef (logic [DATA_W-1:0] at the default width).
  - axis_beat_t struct {tlast, tdata}.
  - Default width and depth constants.
- One sub-module: axis_fifo_mem, a simple dual-port storage array with write enable, write address, read address and asynchronous read data.
- Pointer, counter and handshake logic stay in axis_sync_fifo.

Test Plan:
- Reset, then 16 beats 0x00..0x0F with s_tvalid=1 and m_tready=0:
  - fill_level reaches 16 and s_tready drops after the 16th accept.
  - A 17th beat is held, not lost.
- Full FIFO, m_tready=1 for one cycle while s_tvalid=1:
  - One read (0x00 out).
  - No write that cycle; s_tready=1 next cycle; fill_level goes 16 -> 15 -> 16.
- Continuous streaming, both valid and ready high for 100 beats, random data:
  - Output matches input in order.
  - Throughput is 1 beat/cycle after a 1-cycle initial latency; fill_level stays at 1.
- Packets of lengths 1, 3, 5 with random m_tready:
  - tlast is preserved at beats 1, 4, 9.
  - pkt_count peaks correctly and returns to 0.
- Assert rst after beat 2 of a 5-beat packet:
  - Next cycle fill_level=0, pkt_count=0, m_tvalid=0.
  - A fresh packet afterwards passes intact.
- With AXIS_SYNC_FIFO_PKT_MODE_EN:
  - A 3-beat packet is not presented until its tlast is written.
  - A 20-beat packet is released once fill_level=16 and drains completely, with release_q clearing on its tlast.
